// File: rtl/instr_fetch.sv
// Instruction sequencer: PC, synchronous instruction-memory read, valid/ready delivery.
// Optional delivered-instruction counter enabled by defining INSTR_FETCH_COUNT_EN.
module instr_fetch #(
   parameter int unsigned         ADDR_W    = 8,
   parameter int unsigned         INSTR_W   = 20,
   parameter logic [INSTR_W-1:0]  HALT_WORD = 20'hFFFFF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               Start,
   input  logic               Salto,
   input  logic [ADDR_W-1:0]  DirSalto,
   output logic [ADDR_W-1:0]  MemDir,
   output logic               MemRe,
   input  logic [INSTR_W-1:0] MemDato,
   output logic [INSTR_W-1:0] Instruction,
   output logic               Valido,
   input  logic               Listo,
   output logic [ADDR_W-1:0]  PC,
   output logic               Ocupado,
   output logic               Halt,
   output logic [15:0]        Contador
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StHold,
      StDone
   } state_e;

   localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 valid_q, valid_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d = StReq;
               pc_d    = '0;
            end
         end
         StReq: begin
            if (Salto) begin
               pc_d    = DirSalto;
               state_d = StReq;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            // A jump discards the in-flight read; the halt word is never delivered.
            if (Salto) begin
               pc_d    = DirSalto;
               state_d = StReq;
            end else if (MemDato == HALT_WORD) begin
               state_d = StDone;
            end else begin
               instr_d = MemDato;
               valid_d = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            if (Listo) begin
               valid_d = 1'b0;
               pc_d    = Salto ? DirSalto : pc_q + PcOne;
               state_d = StReq;
            end else if (Salto) begin
               valid_d = 1'b0;
               pc_d    = DirSalto;
               state_d = StReq;
            end
         end
         StDone: begin
            if (Start) begin
               state_d = StReq;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   assign MemDir      = pc_q;
   assign MemRe       = (state_q == StReq);
   assign PC          = pc_q;
   assign Instruction = instr_q;
   assign Valido      = valid_q;
   assign Halt        = (state_q == StDone);
   assign Ocupado     = (state_q == StReq) || (state_q == StWait) || (state_q == StHold);

`ifdef INSTR_FETCH_COUNT_EN
   logic        cnt_accept;
   logic        cnt_clr;
   logic [15:0] count_q;

   // Valido is only ever high in HOLD, so this is exactly the handshake.
   assign cnt_accept = valid_q && Listo;
   assign cnt_clr    = Start && ((state_q == StIdle) || (state_q == StDone));

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else if (cnt_clr) begin
         count_q <= '0;
      end else if (cnt_accept) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign Contador = count_q;
`else
   assign Contador = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs, expected words queued by stimulus,
// a negedge monitor pops and compares on every accepted handshake.
module tb_instr_fetch;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 20;
   localparam logic [19:0] HALTW   = 20'hFFFFF;
`ifdef INSTR_FETCH_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic               CLK = 1'b0;
   logic               RST;
   logic               Start;
   logic               Salto;
   logic [ADDR_W-1:0]  DirSalto;
   logic [ADDR_W-1:0]  MemDir;
   logic               MemRe;
   logic [INSTR_W-1:0] MemDato;
   logic [INSTR_W-1:0] Instruction;
   logic               Valido;
   logic               Listo;
   logic [ADDR_W-1:0]  PC;
   logic               Ocupado;
   logic               Halt;
   logic [15:0]        Contador;

   logic [INSTR_W-1:0] mem [256];
   logic [INSTR_W-1:0] exp_q [$];
   int n_cmp = 0;
   int n_bad = 0;

   instr_fetch dut (
      .CLK        (CLK),
      .RST        (RST),
      .Start      (Start),
      .Salto      (Salto),
      .DirSalto   (DirSalto),
      .MemDir     (MemDir),
      .MemRe      (MemRe),
      .MemDato    (MemDato),
      .Instruction(Instruction),
      .Valido     (Valido),
      .Listo      (Listo),
      .PC         (PC),
      .Ocupado    (Ocupado),
      .Halt       (Halt),
      .Contador   (Contador)
   );

   always #5 CLK = ~CLK;

   // Synchronous memory: data valid one cycle after MemRe.
   always @(posedge CLK) begin
      if (MemRe) MemDato <= mem[MemDir];
   end

   function automatic void check(input string nm, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Monitor: every accepted word must be the next expected one.
   always @(negedge CLK) begin
      if (!RST && Valido && Listo) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %h expected none", Instruction);
         end else begin
            check("delivered_word", {12'd0, Instruction}, {12'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_halt(input string nm);
      int n = 0;
      while (!Halt && n < 40) begin
         tick();
         n++;
      end
      check(nm, {31'd0, Halt}, 32'd1);
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 20'h00000;
      MemDato  = '0;
      RST      = 1'b1;
      Start    = 1'b0;
      Salto    = 1'b0;
      DirSalto = '0;
      Listo    = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      check("rst_valido", {31'd0, Valido}, 32'd0);
      check("rst_pc", {24'd0, PC}, 32'd0);
      check("rst_memre", {31'd0, MemRe}, 32'd0);
      check("rst_ocupado", {31'd0, Ocupado}, 32'd0);

      // Salto in IDLE is ignored.
      Salto = 1'b1; DirSalto = 8'h40;
      tick();
      Salto = 1'b0;
      check("idle_salto_pc", {24'd0, PC}, 32'd0);
      check("idle_salto_ocupado", {31'd0, Ocupado}, 32'd0);

      // Reset while holding a valid word.
      mem[0] = 20'h12345;
      pulse_start();
      tick();
      tick();
      check("pre_rst_valido", {31'd0, Valido}, 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("midhold_rst_valido", {31'd0, Valido}, 32'd0);
      check("midhold_rst_pc", {24'd0, PC}, 32'd0);
      check("midhold_rst_halt", {31'd0, Halt}, 32'd0);
      check("midhold_rst_ocupado", {31'd0, Ocupado}, 32'd0);
      check("midhold_rst_cnt", {16'd0, Contador}, 32'd0);
      check("midhold_rst_instr", {12'd0, Instruction}, 32'd0);

      // Straight-line program with Listo held high.
      mem[0] = 20'h0A1C0; mem[1] = 20'h10240; mem[2] = HALTW;
      exp_q.push_back(20'h0A1C0);
      exp_q.push_back(20'h10240);
      Listo = 1'b1;
      pulse_start();
      check("sl_memre", {31'd0, MemRe}, 32'd1);
      check("sl_memdir", {24'd0, MemDir}, 32'd0);
      check("sl_ocupado", {31'd0, Ocupado}, 32'd1);
      tick();
      check("sl_wait_valido", {31'd0, Valido}, 32'd0);
      tick();
      check("sl_first_valido", {31'd0, Valido}, 32'd1);
      check("sl_first_instr", {12'd0, Instruction}, 32'h0A1C0);
      tick();
      tick();
      check("sl_gap_valido", {31'd0, Valido}, 32'd0);
      tick();
      check("sl_second_valido", {31'd0, Valido}, 32'd1);
      check("sl_second_instr", {12'd0, Instruction}, 32'h10240);
      wait_halt("sl_halt");
      check("sl_halt_pc", {24'd0, PC}, 32'd2);
      check("sl_halt_valido", {31'd0, Valido}, 32'd0);
      check("sl_halt_memre", {31'd0, MemRe}, 32'd0);
      check("sl_halt_cnt", {16'd0, Contador}, CNT_ON ? 32'd2 : 32'd0);
      check("sl_queue_empty", exp_q.size(), 32'd0);

      // Backpressure in HOLD, restarting from DONE.
      mem[0] = 20'h11111; mem[1] = 20'h22222; mem[2] = HALTW;
      exp_q.push_back(20'h11111);
      exp_q.push_back(20'h22222);
      Listo = 1'b0;
      pulse_start();
      check("bp_restart_halt", {31'd0, Halt}, 32'd0);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valido", {31'd0, Valido}, 32'd1);
         check("bp_instr", {12'd0, Instruction}, 32'h11111);
         check("bp_memre", {31'd0, MemRe}, 32'd0);
         check("bp_pc", {24'd0, PC}, 32'd0);
         tick();
      end
      Listo = 1'b1;
      tick();
      check("bp_pc_inc", {24'd0, PC}, 32'd1);
      check("bp_memre_next", {31'd0, MemRe}, 32'd1);
      tick();
      tick();
      check("bp_next_valido", {31'd0, Valido}, 32'd1);
      check("bp_next_instr", {12'd0, Instruction}, 32'h22222);
      wait_halt("bp_halt");
      check("bp_cnt", {16'd0, Contador}, CNT_ON ? 32'd2 : 32'd0);
      check("bp_queue_empty", exp_q.size(), 32'd0);

      // Jump during WAIT discards the read; jump with Listo in HOLD delivers first.
      mem[0] = 20'h33333; mem[8'h40] = 20'h44444; mem[8'h80] = HALTW;
      exp_q.push_back(20'h44444);
      Listo = 1'b0;
      pulse_start();
      tick();
      Salto = 1'b1; DirSalto = 8'h40;
      tick();
      Salto = 1'b0;
      check("jw_memre", {31'd0, MemRe}, 32'd1);
      check("jw_memdir", {24'd0, MemDir}, 32'h40);
      check("jw_valido", {31'd0, Valido}, 32'd0);
      tick();
      tick();
      check("jw_hold_instr", {12'd0, Instruction}, 32'h44444);
      Listo = 1'b1; Salto = 1'b1; DirSalto = 8'h80;
      tick();
      Salto = 1'b0;
      check("jh_memdir", {24'd0, MemDir}, 32'h80);
      check("jh_memre", {31'd0, MemRe}, 32'd1);
      wait_halt("jh_halt");
      check("jh_pc", {24'd0, PC}, 32'h80);
      check("jh_cnt", {16'd0, Contador}, CNT_ON ? 32'd1 : 32'd0);
      check("jh_queue_empty", exp_q.size(), 32'd0);

      // PC wrap from 8'hFF to 8'h00.
      mem[8'hFF] = 20'h55555; mem[0] = 20'h66666; mem[1] = HALTW;
      exp_q.push_back(20'h55555);
      exp_q.push_back(20'h66666);
      Listo = 1'b1;
      pulse_start();
      Salto = 1'b1; DirSalto = 8'hFF;
      tick();
      Salto = 1'b0;
      check("wr_memdir_ff", {24'd0, MemDir}, 32'hFF);
      tick();
      tick();
      check("wr_instr_ff", {12'd0, Instruction}, 32'h55555);
      tick();
      check("wr_memdir_00", {24'd0, MemDir}, 32'h00);
      check("wr_memre_00", {31'd0, MemRe}, 32'd1);
      wait_halt("wr_halt");
      check("wr_pc", {24'd0, PC}, 32'd1);
      check("wr_cnt", {16'd0, Contador}, CNT_ON ? 32'd2 : 32'd0);
      check("wr_queue_empty", exp_q.size(), 32'd0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
